// File: rtl/pulse_sequencer.sv
// Triggered spin-echo / CPMG RF pulse sequencer: dead -> pi/2 -> tau -> N x (pi, 2*tau echo) -> done.
// Optional macro PHASE_CYCLE_EN enables pi-pulse phase alternation on the phase output.
module pulse_sequencer #(
    parameter int CNT_W  = 24,
    parameter int ECHO_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig,
    input  logic              abort,
    input  logic [CNT_W-1:0]  dead_cnt,
    input  logic [CNT_W-1:0]  p90_cnt,
    input  logic [CNT_W-1:0]  tau_cnt,
    input  logic [ECHO_W-1:0] n_echo,
    output logic              rf,
    output logic              acq,
    output logic              phase,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int SEG_W = CNT_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEAD,
        S_P90,
        S_TAU,
        S_P180,
        S_ECHO
    } state_t;

    state_t            state_reg, state_next;
    logic [SEG_W-1:0]  seg_cnt_reg, seg_next;
    logic [ECHO_W-1:0] echo_cnt_reg, echo_next;
    logic [CNT_W-1:0]  p90_lat_reg, tau_lat_reg;
    logic [ECHO_W-1:0] n_lat_reg;
    logic              sync1_reg, sync2_reg, sync3_reg, edge_reg;
    logic              done_reg, done_next;
    logic              overrun_reg, overrun_set;
    logic              start;
    logic [SEG_W-1:0]  p180_len, echo_len;

    // Segment counter holds (length - 1) and counts down; a zero length still lasts one cycle.
    function automatic logic [SEG_W-1:0] last_idx(input logic [SEG_W-1:0] len);
        return (len == '0) ? '0 : len - 1'b1;
    endfunction

    assign p180_len = {p90_lat_reg, 1'b0};
    assign echo_len = {tau_lat_reg, 1'b0};

`ifdef PHASE_CYCLE_EN
    logic phase_reg, phase_next;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg    <= 1'b0;
            sync2_reg    <= 1'b0;
            sync3_reg    <= 1'b0;
            edge_reg     <= 1'b0;
            state_reg    <= S_IDLE;
            seg_cnt_reg  <= '0;
            echo_cnt_reg <= '0;
            p90_lat_reg  <= '0;
            tau_lat_reg  <= '0;
            n_lat_reg    <= '0;
            done_reg     <= 1'b0;
            overrun_reg  <= 1'b0;
`ifdef PHASE_CYCLE_EN
            phase_reg    <= 1'b0;
`endif
        end else begin
            sync1_reg    <= trig;
            sync2_reg    <= sync1_reg;
            sync3_reg    <= sync2_reg;
            // Registered edge pulse puts the start exactly three cycles after trig is first sampled.
            edge_reg     <= sync2_reg & ~sync3_reg;
            state_reg    <= state_next;
            seg_cnt_reg  <= seg_next;
            echo_cnt_reg <= echo_next;
            done_reg     <= done_next;
            overrun_reg  <= overrun_reg | overrun_set;
            if (start) begin
                p90_lat_reg <= p90_cnt;
                tau_lat_reg <= tau_cnt;
                n_lat_reg   <= n_echo;
            end
`ifdef PHASE_CYCLE_EN
            phase_reg    <= phase_next;
`endif
        end
    end

    always_comb begin
        state_next  = state_reg;
        seg_next    = seg_cnt_reg;
        echo_next   = echo_cnt_reg;
        done_next   = 1'b0;
        start       = 1'b0;
        overrun_set = 1'b0;

        if (state_reg == S_IDLE) begin
            if (edge_reg && !abort) begin
                start      = 1'b1;
                state_next = S_DEAD;
                seg_next   = last_idx({1'b0, dead_cnt});
            end
        end else if (abort) begin
            state_next = S_IDLE;
            seg_next   = '0;
            echo_next  = '0;
        end else begin
            overrun_set = edge_reg;
            if (seg_cnt_reg != '0) begin
                seg_next = seg_cnt_reg - 1'b1;
            end else begin
                case (state_reg)
                    S_DEAD: begin
                        state_next = S_P90;
                        seg_next   = last_idx({1'b0, p90_lat_reg});
                    end
                    S_P90: begin
                        state_next = S_TAU;
                        seg_next   = last_idx({1'b0, tau_lat_reg});
                    end
                    S_TAU: begin
                        if (n_lat_reg == '0) begin
                            state_next = S_IDLE;
                            done_next  = 1'b1;
                        end else begin
                            state_next = S_P180;
                            seg_next   = last_idx(p180_len);
                            echo_next  = n_lat_reg - 1'b1;
                        end
                    end
                    S_P180: begin
                        state_next = S_ECHO;
                        seg_next   = last_idx(echo_len);
                    end
                    S_ECHO: begin
                        if (echo_cnt_reg == '0) begin
                            state_next = S_IDLE;
                            done_next  = 1'b1;
                        end else begin
                            state_next = S_P180;
                            seg_next   = last_idx(p180_len);
                            echo_next  = echo_cnt_reg - 1'b1;
                        end
                    end
                    default: begin
                        state_next = S_IDLE;
                        seg_next   = '0;
                    end
                endcase
            end
        end

`ifdef PHASE_CYCLE_EN
        phase_next = phase_reg;
        if (state_next == S_IDLE || (state_next == S_P90 && state_reg != S_P90))
            phase_next = 1'b0;
        else if (state_next == S_P180 && state_reg != S_P180)
            phase_next = ~phase_reg;
`endif
    end

    always_comb begin
        rf   = (state_reg == S_P90) || (state_reg == S_P180);
        acq  = (state_reg == S_ECHO);
        busy = (state_reg != S_IDLE);
    end

    assign done    = done_reg;
    assign overrun = overrun_reg;
`ifdef PHASE_CYCLE_EN
    assign phase   = phase_reg;
`else
    assign phase   = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_sequencer.sv
// Scoreboard bench for pulse_sequencer: a segment-list reference model queues expected
// per-cycle outputs; a negedge monitor pops and compares them.
module tb_pulse_sequencer;
    localparam int CNT_W  = 24;
    localparam int ECHO_W = 8;
    localparam int NEVER  = 1 << 30;
`ifdef PHASE_CYCLE_EN
    localparam bit PH_EN = 1'b1;
`else
    localparam bit PH_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              trig = 1'b0;
    logic              abort = 1'b0;
    logic [CNT_W-1:0]  dead_cnt = '0, p90_cnt = '0, tau_cnt = '0;
    logic [ECHO_W-1:0] n_echo = '0;
    logic              rf, acq, phase, busy, done, overrun;

    pulse_sequencer #(.CNT_W(CNT_W), .ECHO_W(ECHO_W)) dut (
        .clk(clk), .rst(rst), .trig(trig), .abort(abort),
        .dead_cnt(dead_cnt), .p90_cnt(p90_cnt), .tau_cnt(tau_cnt), .n_echo(n_echo),
        .rf(rf), .acq(acq), .phase(phase), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // cyc = number of posedges so far; every expected record is tagged with it.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         tag;
        logic [5:0] v;   // {rf, acq, busy, done, phase, overrun}
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   ovr_tag  = NEVER;

    function automatic int seg(input int x);
        return (x == 0) ? 1 : x;
    endfunction

    function automatic int run_len(input int d, p, t, n);
        return seg(d) + seg(p) + seg(t) + n * (seg(2 * p) + seg(2 * t));
    endfunction

    task automatic push(input int tag, input bit r, a, b, dn, ph);
        exp_t e;
        e.tag = tag;
        e.v   = {r, a, b, dn, ph, (tag >= ovr_tag)};
        exp_q.push_back(e);
    endtask

    task automatic add_seg(input int len, input bit r, a, ph, input int t0, lim, inout int tg);
        for (int i = 0; i < len; i++) begin
            if (tg - t0 < lim) push(tg, r, a, 1'b1, 1'b0, ph);
            tg++;
        end
    endtask

    task automatic push_busy(input int t0, d, p, t, n, lim);
        int tg;
        bit ph;
        tg = t0;
        add_seg(seg(d), 1'b0, 1'b0, 1'b0, t0, lim, tg);
        add_seg(seg(p), 1'b1, 1'b0, 1'b0, t0, lim, tg);
        add_seg(seg(t), 1'b0, 1'b0, 1'b0, t0, lim, tg);
        for (int i = 1; i <= n; i++) begin
            ph = PH_EN & (i % 2 == 1);
            add_seg(seg(2 * p), 1'b1, 1'b0, ph, t0, lim, tg);
            add_seg(seg(2 * t), 1'b0, 1'b1, ph, t0, lim, tg);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s got=%0h want=%0h", nm, act, req);
    endtask

    task automatic wait_tag(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ab_rel: busy cycle in which abort is held (-1 none); rt_rel: busy cycle of a second
    // trigger edge (-1 none); chain_out: trigger the next run to coincide with done.
    task automatic do_run(input int d, p, t, n, ab_rel, rt_rel, input bit chain_out, chained_in);
        int k, t0, L, lb, dr, end_tag;
        k  = cyc;
        dead_cnt = CNT_W'(d);
        p90_cnt  = CNT_W'(p);
        tau_cnt  = CNT_W'(t);
        n_echo   = ECHO_W'(n);
        if (!chained_in) begin
            trig = 1'b1;
            for (int j = 1; j <= 3; j++) push(k + j, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        t0 = k + 4;
        L  = run_len(d, p, t, n);
        lb = (ab_rel >= 0) ? ab_rel + 1 : L;
        dr = -100;
        if (rt_rel >= 0) begin
            dr = t0 + rt_rel - 3;
            if (rt_rel != ab_rel && t0 + rt_rel + 1 < ovr_tag) ovr_tag = t0 + rt_rel + 1;
        end
        $display("run t0=%0d dead=%0d p90=%0d tau=%0d n=%0d len=%0d abort=%0d retrig=%0d chain=%0b",
                 t0, d, p, t, n, L, ab_rel, rt_rel, chain_out);
        push_busy(t0, d, p, t, n, lb);
        if (ab_rel >= 0) begin
            push(t0 + lb, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            push(t0 + lb + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            end_tag = t0 + lb + 1;
        end else begin
            push(t0 + L, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            if (chain_out) begin
                end_tag = t0 + L - 3;
            end else begin
                push(t0 + L + 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                end_tag = t0 + L + 1;
            end
        end
        for (int tg = k + 1; tg <= end_tag; tg++) begin
            wait_tag(tg);
            if (tg == k + 2) trig = 1'b0;
            if (tg == k + 5) begin
                dead_cnt = CNT_W'($urandom);
                p90_cnt  = CNT_W'($urandom);
                tau_cnt  = CNT_W'($urandom);
                n_echo   = ECHO_W'($urandom);
            end
            if (tg == dr) trig = 1'b1;
            if (tg == dr + 2) trig = 1'b0;
            abort = (ab_rel >= 0) && (tg == t0 + ab_rel);
            if (chain_out && tg == end_tag) trig = 1'b1;
        end
        abort = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t       r;
        logic [5:0] act;
        act = {rf, acq, busy, done, phase, overrun};
        while (exp_q.size() > 0 && exp_q[0].tag < cyc) begin
            r = exp_q.pop_front();
            n_checks++;
            $display("FAIL sample_missed tag=%0d want=%b", r.tag, r.v);
        end
        if (exp_q.size() > 0 && exp_q[0].tag == cyc) begin
            r = exp_q.pop_front();
            n_checks++;
            if (act === r.v) n_pass++;
            else $display("FAIL outputs cyc=%0d got{rf,acq,busy,done,phase,ovr}=%b want=%b",
                          cyc, act, r.v);
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL timeout queue=%0d", exp_q.size());
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int k, d, p, t, n, L, ab, rt;
        bit chain, prev_chain;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {26'd0, rf, acq, busy, done, phase, overrun}, 32'd0);
        rst = 1'b0;
        wait_tag(cyc + 2);

        do_run(5, 3, 10, 2, -1, -1, 1'b0, 1'b0);   // reference timing run
        do_run(2, 4, 6, 0, -1, -1, 1'b0, 1'b0);    // FID only
        do_run(0, 0, 0, 1, -1, -1, 1'b0, 1'b0);    // zero counts last one cycle each
        do_run(5, 3, 10, 2, -1, 20, 1'b0, 1'b0);   // retrigger while busy
        do_run(5, 3, 10, 2, -1, -1, 1'b0, 1'b0);   // overrun stays sticky
        do_run(5, 3, 10, 2, 30, -1, 1'b0, 1'b0);   // abort mid-echo
        do_run(4, 2, 7, 3, -1, -1, 1'b0, 1'b0);
        do_run(3, 2, 4, 1, -1, -1, 1'b1, 1'b0);    // next trigger lands on done
        do_run(2, 1, 2, 2, -1, -1, 1'b0, 1'b1);
        do_run(6, 2, 5, 2, 12, 12, 1'b0, 1'b0);    // abort and edge together

        // Abort in IDLE, and abort coincident with a start edge: nothing starts.
        k = cyc;
        trig = 1'b1;
        for (int j = 1; j <= 6; j++) push(k + j, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_tag(k + 2); trig  = 1'b0;
        wait_tag(k + 3); abort = 1'b1;
        wait_tag(k + 4); abort = 1'b0;
        wait_tag(k + 6);

        // Asynchronous reset in the middle of the second pi pulse.
        k = cyc;
        dead_cnt = 24'd5; p90_cnt = 24'd3; tau_cnt = 24'd10; n_echo = 8'd2;
        trig = 1'b1;
        wait_tag(k + 2); trig = 1'b0;
        wait_tag(k + 4 + 45);
        #2;
        chk("rf_in_p180", {31'd0, rf}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_reset", {26'd0, rf, acq, busy, done, phase, overrun}, 32'd0);
        ovr_tag = NEVER;
        @(posedge clk); #1;
        rst = 1'b0;
        wait_tag(cyc + 2);

        prev_chain = 1'b0;
        for (int i = 0; i < 30; i++) begin
            d = $urandom_range(0, 8);
            p = $urandom_range(0, 5);
            t = $urandom_range(0, 8);
            n = $urandom_range(0, 4);
            L = run_len(d, p, t, n);
            ab = ($urandom % 4 == 0) ? $urandom_range(0, L - 1) : -1;
            rt = -1;
            if (L >= 8 && $urandom % 3 == 0) begin
                rt = $urandom_range(3, L - 5);
                if (ab >= 0 && rt > ab) rt = (ab >= 3) ? ab : -1;
            end
            chain = (ab < 0) && (i != 29) && ($urandom % 4 == 0);
            do_run(d, p, t, n, ab, rt, chain, prev_chain);
            prev_chain = chain;
        end

        for (int j = 0; j < 20 && exp_q.size() > 0; j++) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
